// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one command at a time through an external ALU.
// Flow is accept (IDLE) -> capture result (EXEC) -> hand off result (RESP).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_sel/cmd_data/cmd_cin/cmd_wb opcode, B operand, carry-in, write-back
//   alu_a/alu_b/alu_sel/alu_cin     operands driven to the external ALU
//   alu_y                           combinational ALU result
//   res_valid/res_ready/res_data    result handshake and captured value
//   op_cnt                          completed result handshakes (wraps)
//   res_zero/res_sign               result flags, only with ALU_CTRL_FLAGS_EN
module alu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_sel,
    input  logic [7:0] cmd_data,
    input  logic       cmd_cin,
    input  logic       cmd_wb,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    output logic       alu_cin,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] op_cnt
`ifdef ALU_CTRL_FLAGS_EN
    ,
    output logic       res_zero,
    output logic       res_sign
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       rdy_q;
    logic       wb_q;
    logic [7:0] acc;
    logic       accept;
    logic       done;

    // cmd_ready is registered so it stays low throughout reset and
    // rises on the first edge after release, even though state is IDLE.
    assign cmd_ready = rdy_q;
    assign alu_a     = acc;
    assign res_valid = (state == RESP);
    assign accept    = (state == IDLE) && cmd_valid && rdy_q;
    assign done      = (state == RESP) && res_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_b    <= 8'h00;
            alu_sel  <= 4'h0;
            alu_cin  <= 1'b0;
            wb_q     <= 1'b0;
            acc      <= 8'h00;
            res_data <= 8'h00;
            op_cnt   <= 8'h00;
        end else begin
            if (accept) begin
                alu_b   <= cmd_data;
                alu_sel <= cmd_sel;
                alu_cin <= cmd_cin;
                wb_q    <= cmd_wb;
            end
            if (state == EXEC) begin
                res_data <= alu_y;
                if (wb_q) acc <= alu_y;
            end
            if (done) op_cnt <= op_cnt + 8'h01;
        end
    end

`ifdef ALU_CTRL_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero <= 1'b0;
            res_sign <= 1'b0;
        end else if (state == EXEC) begin
            res_zero <= (alu_y == 8'h00);
            res_sign <= alu_y[7];
        end
    end
`endif

endmodule
